// File: rtl/l1_mem_arbiter_pkg.sv
// Shared types for the two-port L1 memory arbiter.
package l1_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } t_arb_state;

  // Index of one of the two requesting caches.
  typedef logic t_port_idx;

  // Number of DATA_WIDTH beats needed to move one cache line.
  function automatic int unsigned beats_for(input int unsigned line_bytes,
                                            input int unsigned data_bits);
    return line_bytes / (data_bits / 8);
  endfunction

endpackage

// File: rtl/l1_mem_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie the port that did not own the last burst wins.
module mem_rr_pick
  import l1_mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  t_port_idx  i_last,
  output t_port_idx  o_gnt_idx,
  output logic       o_any
);

  // Pick the lone requester, or the non-last port when both request.
  always_comb begin
    o_any     = |i_req;
    o_gnt_idx = 1'b0;
    if (&i_req) begin
      o_gnt_idx = ~i_last;
    end else if (i_req[1]) begin
      o_gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Burst-locked round-robin arbiter sharing one memory port between two L1 caches.
module l1_mem_arbiter
  import l1_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_SIZE  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_p0_mem_read_en,
  input  logic                  i_p0_mem_write_en,
  input  logic [ADDR_WIDTH-1:0] i_p0_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_p0_mem_write_data,
  output logic [DATA_WIDTH-1:0] o_p0_mem_read_data,
  output logic                  o_p0_mem_data_valid,
  input  logic                  i_p1_mem_read_en,
  input  logic                  i_p1_mem_write_en,
  input  logic [ADDR_WIDTH-1:0] i_p1_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_p1_mem_write_data,
  output logic [DATA_WIDTH-1:0] o_p1_mem_read_data,
  output logic                  o_p1_mem_data_valid,
  output logic                  o_mem_read_en,
  output logic                  o_mem_write_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data,
  input  logic                  i_mem_data_valid,
  output logic                  o_busy,
  output logic                  o_grant
);

  localparam int unsigned      BEATS     = beats_for(LINE_SIZE, DATA_WIDTH);
  localparam int unsigned      CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_beats_chk
    $error("l1_mem_arbiter: BEATS must be a power of two and at least 2");
  end

  t_arb_state            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
  t_port_idx             r_grant, w_grant_nxt;
  t_port_idx             r_last_grant, w_last_grant_nxt;

  logic [1:0]            w_req;
  t_port_idx             w_pick_idx;
  logic                  w_pick_any;
  logic                  w_xfer;
  logic                  w_sel_rd, w_sel_wr, w_sel_active;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  assign w_req = {i_p1_mem_read_en | i_p1_mem_write_en,
                  i_p0_mem_read_en | i_p0_mem_write_en};

  mem_rr_pick u_pick (
    .i_req     (w_req),
    .i_last    (r_last_grant),
    .o_gnt_idx (w_pick_idx),
    .o_any     (w_pick_any)
  );

  // Granted-port view of the request; read takes precedence over write.
  assign w_sel_rd     = r_grant ? i_p1_mem_read_en    : i_p0_mem_read_en;
  assign w_sel_wr     = r_grant ? i_p1_mem_write_en   : i_p0_mem_write_en;
  assign w_sel_addr   = r_grant ? i_p1_mem_addr       : i_p0_mem_addr;
  assign w_sel_wdata  = r_grant ? i_p1_mem_write_data : i_p0_mem_write_data;
  assign w_sel_active = w_sel_rd | w_sel_wr;

  // Outputs are forced quiet while reset is held, even mid-burst.
  assign w_xfer = (r_state == XFER) && !i_rst;

  assign o_mem_read_en       = w_xfer & w_sel_rd;
  assign o_mem_write_en      = w_xfer & w_sel_wr & ~w_sel_rd;
  assign o_mem_addr          = w_xfer ? w_sel_addr  : '0;
  assign o_mem_write_data    = w_xfer ? w_sel_wdata : '0;
  assign o_p0_mem_data_valid = w_xfer & ~r_grant & i_mem_data_valid;
  assign o_p1_mem_data_valid = w_xfer &  r_grant & i_mem_data_valid;
  assign o_p0_mem_read_data  = (w_xfer && !r_grant) ? i_mem_read_data : '0;
  assign o_p1_mem_read_data  = (w_xfer &&  r_grant) ? i_mem_read_data : '0;
  assign o_busy              = w_xfer;
  assign o_grant             = r_grant & ~i_rst;

  // Arbitration, beat counting, and burst completion/abort decisions.
  always_comb begin
    w_state_nxt      = r_state;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (i_mem_data_valid) begin
          if (r_beat_cnt == LAST_BEAT) begin
            w_state_nxt    = RELEASE;
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end else if (!w_sel_active) begin
          w_state_nxt    = RELEASE;
          w_beat_cnt_nxt = '0;
        end
      end
      RELEASE: begin
        w_last_grant_nxt = r_grant;
        w_state_nxt      = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_beat_cnt   <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed scenarios plus randomized traffic.
module tb_l1_mem_arbiter;

  localparam int BEATS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_rd, p0_wr, p1_rd, p1_wr, mem_valid;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rdata;
  logic [31:0] o_p0_rdata, o_p1_rdata, o_addr, o_wdata;
  logic        o_p0_valid, o_p1_valid, o_ren, o_wen, o_busy, o_grant;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural arbiter model: owner -1 means no burst in progress.
  int m_owner   = -1;
  int m_beats   = 0;
  bit m_release = 1'b0;
  bit m_last    = 1'b1;
  bit m_gnt     = 1'b0;

  // Requester (cache) models.
  int          r_left[2];
  int          r_idx[2];
  int          r_abort[2];
  bit          r_rd[2];
  bit          r_both[2];
  bit          r_cont[2];
  logic [31:0] r_base[2];

  // Memory valid pattern: 1 every cycle, 3 every third cycle, 0 random.
  int vmode = 1;
  bit stray = 1'b0;

  logic [133:0] obs_vec, exp_vec;
  bit           exp_v0, exp_v1;
  logic         obs_v0, obs_v1, obs_busy, obs_grant, obs_wen;
  logic         obs_busy_prev = 1'b0;
  logic [31:0]  obs_rdata0, obs_addr, obs_wdata;
  int           obs_cnt0, obs_cnt1, last_v_cyc0;
  int           obs_gnt_q[$];
  int           obs_rise_q[$];
  int           obs_fall_q[$];

  l1_mem_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .LINE_SIZE  (64)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_p0_mem_read_en    (p0_rd),
    .i_p0_mem_write_en   (p0_wr),
    .i_p0_mem_addr       (p0_addr),
    .i_p0_mem_write_data (p0_wdata),
    .o_p0_mem_read_data  (o_p0_rdata),
    .o_p0_mem_data_valid (o_p0_valid),
    .i_p1_mem_read_en    (p1_rd),
    .i_p1_mem_write_en   (p1_wr),
    .i_p1_mem_addr       (p1_addr),
    .i_p1_mem_write_data (p1_wdata),
    .o_p1_mem_read_data  (o_p1_rdata),
    .o_p1_mem_data_valid (o_p1_valid),
    .o_mem_read_en       (o_ren),
    .o_mem_write_en      (o_wen),
    .o_mem_addr          (o_addr),
    .o_mem_write_data    (o_wdata),
    .i_mem_read_data     (mem_rdata),
    .i_mem_data_valid    (mem_valid),
    .o_busy              (o_busy),
    .o_grant             (o_grant)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic start_line(input int n, input bit rd, input logic [31:0] base);
    r_left[n]  = BEATS;
    r_idx[n]   = 0;
    r_rd[n]    = rd;
    r_base[n]  = base;
    r_abort[n] = 0;
    r_both[n]  = 1'b0;
  endtask

  task automatic clear_reqs();
    for (int n = 0; n < 2; n++) begin
      r_left[n] = 0; r_idx[n] = 0; r_abort[n] = 0;
      r_rd[n] = 1'b0; r_both[n] = 1'b0; r_cont[n] = 1'b0; r_base[n] = '0;
    end
  endtask

  task automatic clear_obs();
    obs_cnt0 = 0; obs_cnt1 = 0; last_v_cyc0 = -1;
    obs_gnt_q.delete(); obs_rise_q.delete(); obs_fall_q.delete();
  endtask

  // Drive cache requests and memory response for the coming cycle.
  task automatic apply();
    bit own_act, pat;
    p0_rd    = (r_left[0] > 0) && r_rd[0];
    p0_wr    = (r_left[0] > 0) && (!r_rd[0] || r_both[0]);
    p0_addr  = (r_left[0] > 0) ? r_base[0] + 32'(4 * r_idx[0]) : $urandom;
    p0_wdata = (r_left[0] > 0) ? 32'hB000_0000 + r_base[0] + 32'(r_idx[0]) : $urandom;
    p1_rd    = (r_left[1] > 0) && r_rd[1];
    p1_wr    = (r_left[1] > 0) && (!r_rd[1] || r_both[1]);
    p1_addr  = (r_left[1] > 0) ? r_base[1] + 32'(4 * r_idx[1]) : $urandom;
    p1_wdata = (r_left[1] > 0) ? 32'hB000_0000 + r_base[1] + 32'(r_idx[1]) : $urandom;
    own_act  = (m_owner == 0) ? (p0_rd | p0_wr) : (m_owner == 1) ? (p1_rd | p1_wr) : 1'b0;
    if (vmode == 1)      pat = 1'b1;
    else if (vmode == 3) pat = (cyc % 3 == 0);
    else                 pat = ($urandom_range(0, 1) == 1);
    mem_valid = (own_act && pat) || (stray && m_owner < 0);
    mem_rdata = (vmode == 0) ? $urandom : 32'hA0 + 32'(m_beats);
  endtask

  // Expected outputs for the current inputs.
  task automatic model_outputs();
    bit b, s1, er, ew;
    logic [31:0] ea, ed, rd0, rd1;
    b      = !rst && m_owner >= 0;
    s1     = (m_owner == 1);
    er     = b && (s1 ? p1_rd : p0_rd);
    ew     = b && !er && (s1 ? p1_wr : p0_wr);
    ea     = b ? (s1 ? p1_addr : p0_addr) : 32'h0;
    ed     = b ? (s1 ? p1_wdata : p0_wdata) : 32'h0;
    exp_v0 = b && !s1 && mem_valid;
    exp_v1 = b && s1 && mem_valid;
    rd0    = (b && !s1) ? mem_rdata : 32'h0;
    rd1    = (b && s1) ? mem_rdata : 32'h0;
    exp_vec = {b, (rst ? 1'b0 : m_gnt), er, ew, ea, ed, exp_v0, exp_v1, rd0, rd1};
  endtask

  // Advance the model by one clock.
  task automatic model_update();
    bit a0, a1, g, own;
    a0 = p0_rd | p0_wr;
    a1 = p1_rd | p1_wr;
    if (rst) begin
      m_owner = -1; m_beats = 0; m_release = 1'b0; m_last = 1'b1; m_gnt = 1'b0;
    end else if (m_release) begin
      m_release = 1'b0;
      m_last    = m_gnt;
    end else if (m_owner >= 0) begin
      own = (m_owner == 0) ? a0 : a1;
      if (mem_valid) begin
        m_beats++;
        if (m_beats == BEATS) begin
          m_owner = -1; m_release = 1'b1; m_beats = 0;
        end
      end else if (!own) begin
        m_owner = -1; m_release = 1'b1; m_beats = 0;
      end
    end else if (a0 || a1) begin
      g       = (a0 && a1) ? !m_last : a1;
      m_owner = g ? 1 : 0;
      m_gnt   = g;
      m_beats = 0;
    end
  endtask

  // Caches step through their line on each beat the model says completed.
  task automatic req_update();
    bit ev[2];
    ev[0] = exp_v0;
    ev[1] = exp_v1;
    for (int n = 0; n < 2; n++) begin
      if (ev[n] && r_left[n] > 0) begin
        r_idx[n]++;
        r_left[n]--;
        if (r_abort[n] != 0 && r_idx[n] == r_abort[n]) r_left[n] = 0;
        if (r_left[n] == 0 && r_cont[n]) start_line(n, r_rd[n], r_base[n]);
      end
    end
  endtask

  // One clock: snapshot DUT at negedge, then advance models after posedge.
  task automatic cycle();
    @(negedge clk);
    model_outputs();
    obs_vec    = {o_busy, o_grant, o_ren, o_wen, o_addr, o_wdata,
                  o_p0_valid, o_p1_valid, o_p0_rdata, o_p1_rdata};
    obs_v0     = o_p0_valid;
    obs_v1     = o_p1_valid;
    obs_busy   = o_busy;
    obs_grant  = o_grant;
    obs_wen    = o_wen;
    obs_rdata0 = o_p0_rdata;
    obs_addr   = o_addr;
    obs_wdata  = o_wdata;
    if (obs_busy && !obs_busy_prev) begin
      obs_gnt_q.push_back(int'(obs_grant));
      obs_rise_q.push_back(cyc);
    end
    if (!obs_busy && obs_busy_prev) obs_fall_q.push_back(cyc);
    obs_busy_prev = obs_busy;
    if (obs_v0) begin obs_cnt0++; last_v_cyc0 = cyc; end
    if (obs_v1) obs_cnt1++;
    @(posedge clk);
    #1;
    model_update();
    req_update();
    apply();
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; stray = 1'b0; clear_reqs(); apply();
    cycle(); cycle();
    rst = 1'b0; apply();
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_reqs(); clear_obs(); apply();
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (obs_vec !== '0) begin
        errors++; $display("FAIL reset_zero cyc %0d got %h exp 0", cyc, obs_vec);
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL reset_model cyc %0d got %h exp %h", cyc, obs_vec, exp_vec);
      end
    end
    rst = 1'b0; apply();
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (obs_busy !== 1'b0 || obs_grant !== 1'b0) begin
        errors++; $display("FAIL reset_idle cyc %0d got busy %b grant %b exp 0 0", cyc, obs_busy, obs_grant);
      end
    end
  endtask

  task automatic test_single_read();
    clear_obs(); vmode = 1;
    start_line(0, 1'b1, 32'h100); apply();
    for (int k = 0; k < 30; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL single_read cyc %0d got %h exp %h", cyc, obs_vec, exp_vec);
      end
      if (obs_v0) begin
        checks++;
        if (obs_rdata0 !== 32'hA0 + 32'(obs_cnt0 - 1) || obs_addr !== 32'h100 + 32'(4 * (obs_cnt0 - 1))) begin
          errors++;
          $display("FAIL single_read_beat %0d got data %h addr %h exp %h %h", obs_cnt0 - 1,
                   obs_rdata0, obs_addr, 32'hA0 + 32'(obs_cnt0 - 1), 32'h100 + 32'(4 * (obs_cnt0 - 1)));
        end
      end
    end
    checks++;
    if (obs_cnt0 != BEATS || obs_cnt1 != 0) begin
      errors++; $display("FAIL single_read_count got p0 %0d p1 %0d exp 16 0", obs_cnt0, obs_cnt1);
    end
    checks++;
    if (obs_fall_q.size() != 1 || obs_fall_q[0] != last_v_cyc0 + 1) begin
      errors++; $display("FAIL single_read_release got %0d falls exp busy low at cyc %0d", obs_fall_q.size(), last_v_cyc0 + 1);
    end
  endtask

  task automatic test_tie();
    do_reset(); clear_obs(); vmode = 1;
    start_line(0, 1'b1, 32'h300); start_line(1, 1'b1, 32'h400); apply();
    for (int k = 0; k < 50; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL tie cyc %0d got %h exp %h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if (obs_gnt_q.size() != 2) begin
      errors++; $display("FAIL tie_grants got %0d bursts exp 2", obs_gnt_q.size());
    end else if (obs_gnt_q[0] != 0 || obs_gnt_q[1] != 1 || obs_rise_q[1] != last_v_cyc0 + 3) begin
      errors++;
      $display("FAIL tie_order got %0d,%0d second at cyc %0d exp 0,1 at cyc %0d",
               obs_gnt_q[0], obs_gnt_q[1], obs_rise_q[1], last_v_cyc0 + 3);
    end
    checks++;
    if (obs_cnt0 != BEATS || obs_cnt1 != BEATS) begin
      errors++; $display("FAIL tie_count got %0d %0d exp 16 16", obs_cnt0, obs_cnt1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_obs(); vmode = 1;
    start_line(0, 1'b1, 32'h800); start_line(1, 1'b1, 32'h900); r_cont[0] = 1'b1; apply();
    for (int k = 0; k < 150 && obs_gnt_q.size() < 3; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL back_to_back cyc %0d got %h exp %h", cyc, obs_vec, exp_vec);
      end
    end
    r_cont[0] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL back_to_back_tail cyc %0d got %h exp %h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if (obs_gnt_q.size() != 3) begin
      errors++; $display("FAIL back_to_back_timeout got %0d bursts exp 3", obs_gnt_q.size());
    end else if (obs_gnt_q[0] != 0 || obs_gnt_q[1] != 1 || obs_gnt_q[2] != 0) begin
      errors++;
      $display("FAIL back_to_back_order got %0d,%0d,%0d exp 0,1,0", obs_gnt_q[0], obs_gnt_q[1], obs_gnt_q[2]);
    end
  endtask

  task automatic test_write_stall();
    clear_obs(); vmode = 3;
    start_line(1, 1'b0, 32'h200); apply();
    for (int k = 0; k < 70; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL write_stall cyc %0d got %h exp %h", cyc, obs_vec, exp_vec);
      end
      if (obs_v1) begin
        checks++;
        if (obs_wdata !== 32'hB000_0200 + 32'(obs_cnt1 - 1) || obs_wen !== 1'b1) begin
          errors++;
          $display("FAIL write_stall_data beat %0d got %h wen %b exp %h wen 1", obs_cnt1 - 1,
                   obs_wdata, obs_wen, 32'hB000_0200 + 32'(obs_cnt1 - 1));
        end
      end
    end
    checks++;
    if (obs_cnt1 != BEATS || obs_cnt0 != 0) begin
      errors++; $display("FAIL write_stall_count got %0d %0d exp 0 16", obs_cnt0, obs_cnt1);
    end
    stray = 1'b1; apply();
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if (obs_v0 !== 1'b0 || obs_v1 !== 1'b0 || obs_busy !== 1'b0) begin
        errors++; $display("FAIL stray_valid cyc %0d got v0 %b v1 %b busy %b exp 0 0 0", cyc, obs_v0, obs_v1, obs_busy);
      end
    end
    stray = 1'b0; apply();
  endtask

  task automatic test_abort();
    do_reset(); clear_obs(); vmode = 1;
    start_line(0, 1'b1, 32'h500); r_abort[0] = 5; apply();
    cycle();
    start_line(1, 1'b1, 32'h600); apply();
    for (int k = 0; k < 50; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL abort cyc %0d got %h exp %h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if (obs_cnt0 != 5 || obs_cnt1 != BEATS) begin
      errors++; $display("FAIL abort_count got %0d %0d exp 5 16", obs_cnt0, obs_cnt1);
    end
    checks++;
    if (obs_fall_q.size() < 1 || obs_fall_q[0] != last_v_cyc0 + 2) begin
      errors++; $display("FAIL abort_release got %0d falls exp first at cyc %0d", obs_fall_q.size(), last_v_cyc0 + 2);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset(); clear_obs(); vmode = 1;
    start_line(0, 1'b1, 32'h700); apply();
    for (int k = 0; k < 40 && obs_cnt0 < 7; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL reset_mid_run cyc %0d got %h exp %h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if (obs_cnt0 != 7) begin
      errors++; $display("FAIL reset_mid_timeout got %0d beats exp 7", obs_cnt0);
    end
    rst = 1'b1; clear_reqs();
    start_line(0, 1'b1, 32'hA00); start_line(1, 1'b1, 32'hB00); apply();
    cycle();
    checks++;
    if (obs_vec !== '0) begin
      errors++; $display("FAIL reset_mid_zero cyc %0d got %h exp 0", cyc, obs_vec);
    end
    rst = 1'b0; apply(); clear_obs();
    cycle();
    checks++;
    if (obs_vec !== '0) begin
      errors++; $display("FAIL reset_mid_idle cyc %0d got %h exp 0", cyc, obs_vec);
    end
    for (int k = 0; k < 50; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL reset_mid_after cyc %0d got %h exp %h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if (obs_gnt_q.size() != 2 || obs_gnt_q[0] != 0 || obs_cnt0 != BEATS || obs_cnt1 != BEATS) begin
      errors++;
      $display("FAIL reset_mid_tie got %0d bursts first %0d beats %0d %0d exp 2 0 16 16",
               obs_gnt_q.size(), (obs_gnt_q.size() > 0) ? obs_gnt_q[0] : -1, obs_cnt0, obs_cnt1);
    end
  endtask

  task automatic test_random();
    do_reset(); clear_obs(); vmode = 0;
    for (int k = 0; k < 2000; k++) begin
      for (int n = 0; n < 2; n++) begin
        if (r_left[n] == 0 && $urandom_range(0, 7) == 0) begin
          start_line(n, ($urandom_range(0, 1) == 1), {$urandom_range(0, 255), 6'b0});
          r_both[n] = ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 3) == 0) r_abort[n] = $urandom_range(1, BEATS - 1);
        end
      end
      stray = ($urandom_range(0, 9) == 0);
      apply();
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", cyc, obs_vec, exp_vec);
      end
    end
    stray = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    clear_obs();
    apply();
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_write_stall();
    test_abort();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Two-port, burst-locked arbiter that shares one lower-level memory port between two L1 cache controllers, for example the I-cache and the D-cache. It sits between the caches' memory interfaces and the memory. It grants one cache at a time and holds the grant for a full line transfer of BEATS words. Arbitration is round-robin so neither cache can starve the other.

## Interface
Parameters:
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: beat (word) width in bits.
- LINE_SIZE, 64: cache line size in bytes.
- BEATS, LINE_SIZE/(DATA_WIDTH/8) = 16: words per line transfer. Derived localparam.

Ports (N = 0, 1):
- i_clk  in  1  sole clock. Rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_pN_mem_read_en  in  1  requester N wants a read beat.
- i_pN_mem_write_en  in  1  requester N wants a write beat.
- i_pN_mem_addr  in  ADDR_WIDTH  beat address.
- i_pN_mem_write_data  in  DATA_WIDTH  write beat data.
- o_pN_mem_read_data  out  DATA_WIDTH  read data, gated to 0 unless the beat is granted to N.
- o_pN_mem_data_valid  out  1  beat complete for N.
- o_mem_read_en  out  1  read enable to memory.
- o_mem_write_en  out  1  write enable to memory.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_write_data  out  DATA_WIDTH  memory write data.
- i_mem_read_data  in  DATA_WIDTH  memory read data.
- i_mem_data_valid  in  1  memory completes the current beat, read or write.
- o_busy  out  1  high while in XFER.
- o_grant  out  1  index of the granted or last-granted port.

## Operation
- **Requests.** A requester is active when its read_en or write_en is high. If both are high, read wins and write is ignored for that beat.
- **Beat handshake.** A requester holds its enable, addr and write_data steady until it sees data_valid. Each cycle with i_mem_data_valid=1 in XFER completes one beat.
- **State machine** (enum in package): IDLE, XFER, RELEASE.
- **IDLE.**
  - If no port is active, stay in IDLE.
  - If exactly one port is active, register the grant to that port and go to XFER.
  - If both are active, grant the port that is not last_grant.
  - After reset, last_grant = 1, so port 0 wins the first tie.
- **XFER.**
  - o_mem_* is muxed combinationally from the granted port.
  - The granted port's enables pass through to memory. The other port sees valid = 0 and read_data = 0.
  - Each i_mem_data_valid increments beat_cnt, which is $clog2(BEATS) bits wide.
  - Completing beat BEATS-1 (beat_cnt == BEATS-1 with valid) moves to RELEASE and clears beat_cnt.
  - If the granted port drops both enables mid-burst with no valid that cycle, the burst is aborted: go to RELEASE and clear beat_cnt.
- **RELEASE.** One cycle with all memory enables at 0. last_grant takes the value of grant. Then go to IDLE.
- **Ignored inputs.**
  - i_mem_data_valid in IDLE or RELEASE: ignored, no valid forwarded, no count change.
  - Requests from the ungranted port during XFER: ignored. The request is held by the requester and served in a later arbitration.
- **Reset.** Reset mid-burst forces IDLE, beat_cnt = 0, last_grant = 1 and grant = 0 on the next edge. The in-flight burst is dropped with no further valid.

## Timing
- **Output values in reset and IDLE.** All outputs are 0 while i_rst=1, and in IDLE/RELEASE, except o_grant: 0 in reset, last-granted index in IDLE/RELEASE.
- **Grant latency.** A request sampled in IDLE at edge k gives XFER and o_mem_*_en asserted in the cycle after edge k, i.e. 1 cycle of arbitration latency.
- **Valid and read data.** o_pN_mem_data_valid and read data are combinational from i_mem_data_valid and i_mem_read_data in the same cycle. The arbiter adds zero latency per beat.
- **Burst-to-burst gap.** Minimum gap between bursts is 2 cycles: RELEASE, then IDLE arbitration.
- **Minimum burst duration.** BEATS + 2 cycles from request to the next possible grant.
- **beat_cnt width.** Wraps only via an explicit clear. BEATS must be a power of two of at least 2; this is checked with an elaboration assertion.

## Structure
- **Package l1_mem_arb_pkg.**
  - State enum t_arb_state: IDLE, XFER, RELEASE, encoded in logic [1:0].
  - Port index typedef.
  - BEATS derivation function.
- **Sub-module mem_rr_pick.** Combinational two-way round-robin selector. Inputs: req[1:0], last. Outputs: gnt_idx, any.
- **Top level.** Holds state, beat_cnt, grant and last_grant registers, plus the muxes.

## Test plan
- **Single read burst.** Reset, then p0 read at addr 0x100 with memory giving valid every cycle and data 0xA0+i. Expect 16 valids on p0 with data 0xA0..0xAF, o_mem_addr tracking p0, RELEASE, then IDLE. p1 valid stays 0 throughout.
- **Tie after reset.** p0 and p1 both request in the same cycle. Expect p0 granted first. p1 is granted 2 cycles after p0's 16th beat.
- **Back-to-back fairness.** p0 requests continuously, p1 requests once. Expect the grant sequence p0, p1, p0. o_grant alternates.
- **Write burst with stalls.** p1 writes with i_mem_data_valid asserted every 3rd cycle. Expect o_mem_write_data equal to p1's data and exactly 16 beats counted. Stray valid in IDLE is not forwarded.
- **Abort.** p0 drops read_en after 5 beats. Expect RELEASE next cycle, beat_cnt 0, and a pending p1 served with a full 16-beat burst.
- **Reset mid-burst.** Assert i_rst at beat 7. Expect all outputs 0 the next cycle and a fresh p0-priority tie resolution after release.
